bomb_controller: RTL and testbench
==================================

BOMB_CONTROLLER -- requirements
Module: bomb_controller

Interface
REQ-001 Parameter FUSE_FRAMES, default 180, number of frame ticks from placement to explosion (1..255).
REQ-002 Parameter BLAST_FRAMES, default 30, number of frame ticks the explosion is shown (1..255).
REQ-003 Parameter COOLDOWN_FRAMES, default 15, number of frame ticks after the blast before the next placement is accepted (0..255).
REQ-004 Parameter GRID_LOG2, default 4, tile size as a power of two; bomb coordinates snap to multiples of 2^GRID_LOG2.
REQ-005 Clk  input  1  system clock; the only clock, and all state changes on its rising edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 frame_clk  input  1  vertical-sync level from the VGA controller, asynchronous to Clk.
REQ-008 place  input  1  level request from keycode decode ("drop bomb" key held).
REQ-009 detonate  input  1  single-Clk chain-reaction pulse from the other player's blast logic.
REQ-010 userX, userY  input  10 each  current player position in pixels.
REQ-011 bombX, bombY  output  10 each  bomb top-left corner in pixels, fed to the color mapper.
REQ-012 bombS  output  10  bomb size: 10'd17 when visible, 10'd0 when hidden.
REQ-013 exploding  output  1  high throughout BLAST.
REQ-014 state  output  2  IDLE=0, ARMED=1, BLAST=2, COOL=3.

Function
REQ-015 frame_clk SHALL be passed through a 2-flop synchronizer, and a rising edge of the synchronized signal SHALL produce a 1-Clk tick; the tick is asserted 3 Clk cycles after the input edge.
REQ-016 place SHALL be rising-edge detected on Clk, so that holding the key produces exactly one request.
REQ-017 In IDLE, a place edge SHALL, on the same clock edge, latch bombX={userX[9:GRID_LOG2],GRID_LOG2'b0} and bombY={userY[9:GRID_LOG2],GRID_LOG2'b0}, load the fuse counter with FUSE_FRAMES, and enter ARMED.
REQ-018 A place edge in ARMED, BLAST or COOL SHALL be ignored and SHALL NOT be queued.
REQ-019 In ARMED, each tick SHALL decrement the fuse counter by 1; when a tick arrives with the counter at 1, the FSM SHALL enter BLAST with the counter loaded to BLAST_FRAMES.
REQ-020 In ARMED, detonate SHALL enter BLAST on the next Clk edge regardless of the counter; if detonate and the final fuse tick coincide, BLAST SHALL be entered exactly once with a count of BLAST_FRAMES.
REQ-021 detonate SHALL be ignored in IDLE, BLAST and COOL.
REQ-022 In BLAST, ticks SHALL count down BLAST_FRAMES; on expiry the FSM SHALL enter COOL with COOLDOWN_FRAMES loaded, or enter IDLE directly if COOLDOWN_FRAMES=0.
REQ-023 In COOL, ticks SHALL count down COOLDOWN_FRAMES, then the FSM SHALL enter IDLE.
REQ-024 bombX/bombY SHALL hold their latched values in ARMED and BLAST, and SHALL be forced to 10'd640/10'd480 (offscreen) in IDLE and COOL.
REQ-025 bombS SHALL be 10'd17 in ARMED and BLAST and 10'd0 otherwise; exploding SHALL equal (state==BLAST); all outputs SHALL be registered.
REQ-026 The counters SHALL be 8 bits wide and SHALL never underflow, because every state exits when a tick arrives with the count at 1.
REQ-027 A tick and a place edge in the same cycle while in IDLE SHALL start ARMED with the full FUSE_FRAMES; that tick SHALL NOT decrement the new count.

Reset
REQ-028 Reset SHALL immediately force the following, in any state and including mid-fuse or mid-blast: state=IDLE, bombX=640, bombY=480, bombS=0, exploding=0, counters=0, synchronizer and edge-detect flops=0.
REQ-029 After Reset deasserts, a place level that was already high SHALL NOT arm a bomb until it falls and rises again.

Verification
REQ-030 With userX=37 and userY=50, place rising in IDLE -> next cycle bombX=32, bombY=48, bombS=17, state=1.
REQ-031 With default parameters, place and then 180 frame_clk edges -> BLAST entered 3 Clk cycles after the 180th edge; exploding high for exactly 30 ticks; COOL for 15 ticks; then IDLE with bombX=640.
REQ-032 detonate pulse after 10 ticks in ARMED -> state=2 on the next Clk; a second detonate during BLAST does not change the count.
REQ-033 place re-pulsed in ARMED, BLAST and COOL -> no change to bombX/bombY or the counters; place held continuously through return to IDLE -> no re-arm.
REQ-034 Reset asserted mid-BLAST, asynchronous to Clk -> outputs reach their reset values before the next Clk edge; after release with place held high -> state stays IDLE.
REQ-035 With COOLDOWN_FRAMES=0, BLAST expiry -> IDLE directly, and a place edge on the following cycle arms a new bomb.

Source files
------------

// File: rtl/bomb_controller.sv
// bomb_controller
// Sequences a single bomb through place -> fuse -> blast -> cooldown, using
// frame ticks derived from the VGA vertical sync as the time base.
//
// Ports
//   Clk              system clock, all state changes on its rising edge
//   Reset            asynchronous, active-high reset
//   frame_clk        vertical-sync level, asynchronous to Clk
//   place            "drop bomb" key level
//   detonate         single-Clk chain-reaction pulse from the other blast
//   userX, userY     player position in pixels
//   bombX, bombY     bomb top-left corner (640/480 when offscreen)
//   bombS            bomb size, 17 when visible, 0 when hidden
//   exploding        high while in BLAST
//   state            IDLE=0, ARMED=1, BLAST=2, COOL=3
//
// state | meaning
// IDLE  | no bomb, waiting for a place edge
// ARMED | bomb on the grid, fuse counting down
// BLAST | explosion shown, blast timer counting down
// COOL  | bomb gone, placement still locked out
module bomb_controller #(
    parameter int FUSE_FRAMES     = 180,
    parameter int BLAST_FRAMES    = 30,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int GRID_LOG2       = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       place,
    input  logic       detonate,
    input  logic [9:0] userX,
    input  logic [9:0] userY,
    output logic [9:0] bombX,
    output logic [9:0] bombY,
    output logic [9:0] bombS,
    output logic       exploding,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_BLAST = 2'd2,
        ST_COOL  = 2'd3
    } state_t;

    localparam logic [7:0] FUSE_CNT  = FUSE_FRAMES[7:0];
    localparam logic [7:0] BLAST_CNT = BLAST_FRAMES[7:0];
    localparam logic [7:0] COOL_CNT  = COOLDOWN_FRAMES[7:0];
    localparam logic [9:0] GRID_MASK = ~((10'd1 << GRID_LOG2) - 10'd1);
    localparam logic [9:0] OFF_X     = 10'd640;
    localparam logic [9:0] OFF_Y     = 10'd480;
    localparam logic [9:0] BOMB_SIZE = 10'd17;

    logic       sync1_q, sync2_q, frame_prev_q;
    logic       place_q, place_ok_q;
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [9:0] bomb_x_q, bomb_x_d;
    logic [9:0] bomb_y_q, bomb_y_d;
    logic [9:0] bomb_s_q, bomb_s_d;
    logic       exploding_q, exploding_d;
    logic       tick, place_edge, visible_d;

    always_comb begin
        tick       = sync2_q & ~frame_prev_q;
        // place_ok_q only rises once place has been seen low, so a key held
        // through reset cannot arm a bomb on release.
        place_edge = place & ~place_q & place_ok_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        bomb_x_d   = bomb_x_q;
        bomb_y_d   = bomb_y_q;
        case (state_q)
            ST_IDLE: begin
                // A coincident tick is deliberately not applied to the new fuse.
                if (place_edge) begin
                    state_d  = ST_ARMED;
                    cnt_d    = FUSE_CNT;
                    bomb_x_d = userX & GRID_MASK;
                    bomb_y_d = userY & GRID_MASK;
                end
            end
            ST_ARMED: begin
                if (detonate || (tick && cnt_q <= 8'd1)) begin
                    state_d = ST_BLAST;
                    cnt_d   = BLAST_CNT;
                end else if (tick) begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_BLAST: begin
                if (tick) begin
                    if (cnt_q <= 8'd1) begin
                        if (COOLDOWN_FRAMES == 0) begin
                            state_d = ST_IDLE;
                            cnt_d   = 8'd0;
                        end else begin
                            state_d = ST_COOL;
                            cnt_d   = COOL_CNT;
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_COOL: begin
                if (tick) begin
                    if (cnt_q <= 8'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        // The latched position lives in the output flops; it only needs to
        // survive ARMED and BLAST, and IDLE always re-latches it.
        visible_d = (state_d == ST_ARMED) || (state_d == ST_BLAST);
        if (!visible_d) begin
            bomb_x_d = OFF_X;
            bomb_y_d = OFF_Y;
        end
        bomb_s_d    = visible_d ? BOMB_SIZE : 10'd0;
        exploding_d = (state_d == ST_BLAST);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            frame_prev_q <= 1'b0;
            place_q      <= 1'b0;
            place_ok_q   <= 1'b0;
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            bomb_x_q     <= OFF_X;
            bomb_y_q     <= OFF_Y;
            bomb_s_q     <= 10'd0;
            exploding_q  <= 1'b0;
        end else begin
            sync1_q      <= frame_clk;
            sync2_q      <= sync1_q;
            frame_prev_q <= sync2_q;
            place_q      <= place;
            place_ok_q   <= place_ok_q | ~place;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bomb_x_q     <= bomb_x_d;
            bomb_y_q     <= bomb_y_d;
            bomb_s_q     <= bomb_s_d;
            exploding_q  <= exploding_d;
        end
    end

    assign bombX     = bomb_x_q;
    assign bombY     = bomb_y_q;
    assign bombS     = bomb_s_q;
    assign exploding = exploding_q;
    assign state     = state_q;

endmodule

// File: tb/tb_bomb_controller.sv
module tb_bomb_controller;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       place = 1'b0;
    logic       detonate = 1'b0;
    logic [9:0] userX = 10'd0;
    logic [9:0] userY = 10'd0;

    logic [9:0] a_bx, a_by, a_bs, b_bx, b_by, b_bs;
    logic       a_ex, b_ex;
    logic [1:0] a_st, b_st;

    // A: default parameters. B: short timers, no cooldown, 8-pixel grid.
    bomb_controller dut_a (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .place(place),
        .detonate(detonate), .userX(userX), .userY(userY),
        .bombX(a_bx), .bombY(a_by), .bombS(a_bs), .exploding(a_ex), .state(a_st)
    );

    bomb_controller #(.FUSE_FRAMES(3), .BLAST_FRAMES(2), .COOLDOWN_FRAMES(0), .GRID_LOG2(3)) dut_b (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .place(place),
        .detonate(detonate), .userX(userX), .userY(userY),
        .bombX(b_bx), .bombY(b_by), .bombS(b_bs), .exploding(b_ex), .state(b_st)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phases end at an absolute frame-tick count.
    int p_fuse[2], p_blast[2], p_cool[2], p_grid[2];
    int m_state[2], m_end[2], m_bx[2], m_by[2];
    int t_cnt;
    bit s1, s2, s3, pprev, pok;

    typedef struct {
        int ux, uy, ax, ay, bx, by;
    } snap_vec_t;
    snap_vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        s1 = 0; s2 = 0; s3 = 0; pprev = 0; pok = 0; t_cnt = 0;
        for (int d = 0; d < 2; d++) begin
            m_state[d] = 0; m_end[d] = 0; m_bx[d] = 0; m_by[d] = 0;
        end
    endtask

    task automatic model_update();
        bit tick, pe;
        if (Reset) begin
            model_reset();
            return;
        end
        // frame_clk sampled at edge k-2 high and k-3 low -> tick used at edge k
        tick = s2 && !s3;
        s3 = s2; s2 = s1; s1 = frame_clk;
        if (tick) t_cnt++;
        pe = place && !pprev && pok;
        pprev = place;
        if (!place) pok = 1;
        for (int d = 0; d < 2; d++) begin
            case (m_state[d])
                0: if (pe) begin
                    m_state[d] = 1;
                    m_end[d]   = t_cnt + p_fuse[d];
                    m_bx[d]    = (int'(userX) >> p_grid[d]) << p_grid[d];
                    m_by[d]    = (int'(userY) >> p_grid[d]) << p_grid[d];
                end
                1: if (detonate || (tick && t_cnt == m_end[d])) begin
                    m_state[d] = 2;
                    m_end[d]   = t_cnt + p_blast[d];
                end
                2: if (tick && t_cnt == m_end[d]) begin
                    if (p_cool[d] == 0) m_state[d] = 0;
                    else begin
                        m_state[d] = 3;
                        m_end[d]   = t_cnt + p_cool[d];
                    end
                end
                default: if (tick && t_cnt == m_end[d]) m_state[d] = 0;
            endcase
        end
    endtask

    task automatic check_model();
        bit vis;
        for (int d = 0; d < 2; d++) begin
            vis = (m_state[d] == 1) || (m_state[d] == 2);
            if (d == 0) begin
                chk("a_state", 32'(a_st), m_state[d]);
                chk("a_bombX", 32'(a_bx), vis ? m_bx[d] : 640);
                chk("a_bombY", 32'(a_by), vis ? m_by[d] : 480);
                chk("a_bombS", 32'(a_bs), vis ? 17 : 0);
                chk("a_exploding", 32'(a_ex), (m_state[d] == 2) ? 1 : 0);
            end else begin
                chk("b_state", 32'(b_st), m_state[d]);
                chk("b_bombX", 32'(b_bx), vis ? m_bx[d] : 640);
                chk("b_bombY", 32'(b_by), vis ? m_by[d] : 480);
                chk("b_bombS", 32'(b_bs), vis ? 17 : 0);
                chk("b_exploding", 32'(b_ex), (m_state[d] == 2) ? 1 : 0);
            end
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_update();
        #1;
        check_model();
    endtask

    task automatic pulse();
        frame_clk = 1'b1;
        repeat (4) step();
        frame_clk = 1'b0;
        repeat (4) step();
    endtask

    task automatic do_reset();
        Reset = 1'b1; place = 1'b0; detonate = 1'b0; frame_clk = 1'b0;
        repeat (2) step();
        Reset = 1'b0;
        step();
    endtask

    task automatic arm(input int ux, input int uy);
        userX = 10'(ux); userY = 10'(uy);
        place = 1'b0; step();
        place = 1'b1; step();
    endtask

    int cnt;

    initial begin
        p_fuse  = '{180, 3};
        p_blast = '{30, 2};
        p_cool  = '{15, 0};
        p_grid  = '{4, 3};
        model_reset();
        vecs[0] = '{37, 50, 32, 48, 32, 48};
        vecs[1] = '{0, 0, 0, 0, 0, 0};
        vecs[2] = '{1023, 1023, 1008, 1008, 1016, 1016};
        vecs[3] = '{15, 16, 0, 16, 8, 16};
        vecs[4] = '{639, 479, 624, 464, 632, 472};
        vecs[5] = '{7, 8, 0, 0, 0, 8};

        // Reset values
        do_reset();
        chk("reset_state", 32'(a_st), 0);
        chk("reset_bombX", 32'(a_bx), 640);
        chk("reset_bombY", 32'(a_by), 480);
        chk("reset_bombS", 32'(a_bs), 0);

        // Coordinate snapping on placement
        for (int i = 0; i < 6; i++) begin
            do_reset();
            arm(vecs[i].ux, vecs[i].uy);
            chk("snap_a_x", 32'(a_bx), vecs[i].ax);
            chk("snap_a_y", 32'(a_by), vecs[i].ay);
            chk("snap_b_x", 32'(b_bx), vecs[i].bx);
            chk("snap_b_y", 32'(b_by), vecs[i].by);
            chk("snap_a_state", 32'(a_st), 1);
            chk("snap_a_size", 32'(a_bs), 17);
        end

        // Full default timeline: fuse latency, blast length, cooldown length
        do_reset();
        arm(37, 50);
        place = 1'b0;
        repeat (179) pulse();
        frame_clk = 1'b1;
        step(); chk("fuse_lat_1", 32'(a_st), 1);
        step(); chk("fuse_lat_2", 32'(a_st), 1);
        step(); chk("fuse_lat_3", 32'(a_st), 2);
        step();
        frame_clk = 1'b0;
        repeat (4) step();
        cnt = 0;
        while (a_st == 2'd2 && cnt < 100) begin pulse(); cnt++; end
        chk("blast_ticks", cnt, 30);
        cnt = 0;
        while (a_st == 2'd3 && cnt < 100) begin pulse(); cnt++; end
        chk("cool_ticks", cnt, 15);
        chk("after_cool_state", 32'(a_st), 0);
        chk("after_cool_bombX", 32'(a_bx), 640);

        // Detonate mid-fuse, second detonate in BLAST does not reload
        do_reset();
        arm(200, 100);
        place = 1'b0;
        repeat (10) pulse();
        detonate = 1'b1; step(); detonate = 1'b0;
        chk("detonate_blast", 32'(a_st), 2);
        repeat (5) pulse();
        detonate = 1'b1; step(); detonate = 1'b0;
        cnt = 0;
        while (a_st == 2'd2 && cnt < 100) begin pulse(); cnt++; end
        chk("blast_after_redetonate", cnt, 25);

        // Place re-pulsed while busy; place held through return to IDLE
        do_reset();
        arm(100, 200);
        userX = 10'd300; userY = 10'd300;
        place = 1'b0; step(); place = 1'b1; step();
        chk("repulse_armed_x", 32'(a_bx), 96);
        chk("repulse_armed_y", 32'(a_by), 192);
        detonate = 1'b1; step(); detonate = 1'b0;
        place = 1'b0; step(); place = 1'b1; step();
        chk("repulse_blast_x", 32'(a_bx), 96);
        cnt = 0;
        while (a_st != 2'd0 && cnt < 100) begin pulse(); cnt++; end
        repeat (5) step();
        chk("held_place_no_rearm", 32'(a_st), 0);

        // Asynchronous reset mid-BLAST, place held across release
        do_reset();
        arm(64, 64);
        detonate = 1'b1; step(); detonate = 1'b0;
        pulse();
        chk("pre_reset_blast", 32'(a_st), 2);
        #3 Reset = 1'b1;
        #1;
        chk("async_rst_state", 32'(a_st), 0);
        chk("async_rst_bombX", 32'(a_bx), 640);
        chk("async_rst_bombY", 32'(a_by), 480);
        chk("async_rst_bombS", 32'(a_bs), 0);
        chk("async_rst_expl", 32'(a_ex), 0);
        model_reset();
        step();
        Reset = 1'b0;
        repeat (5) step();
        chk("held_after_reset", 32'(a_st), 0);

        // Zero cooldown: BLAST -> IDLE, immediate re-arm
        do_reset();
        arm(20, 20);
        place = 1'b0;
        cnt = 0;
        while (b_st != 2'd2 && cnt < 100) begin step(); frame_clk = ~frame_clk; cnt++; end
        chk("b_reached_blast", 32'(b_st), 2);
        cnt = 0;
        while (b_st == 2'd2 && cnt < 100) begin
            frame_clk = (cnt % 8) < 4;
            step();
            cnt++;
        end
        chk("b_cool0_idle", 32'(b_st), 0);
        place = 1'b1; step();
        chk("b_rearm_next", 32'(b_st), 1);
        frame_clk = 1'b0; place = 1'b0;

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 3) == 0) frame_clk = ~frame_clk;
            if ($urandom_range(0, 9) == 0) place = ~place;
            detonate = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 15) == 0) begin
                userX = 10'($urandom_range(0, 1023));
                userY = 10'($urandom_range(0, 1023));
            end
            Reset = ($urandom_range(0, 799) == 0);
            step();
        end
        Reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
